// File: rtl/pipe_stage_reg.sv
// Single-beat valid/ready pipeline register; define PIPE_STAGE_SKID_EN to add a
// skid entry that makes in_ready a registered signal instead of a combinational one.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             in_xfer;
    logic             out_xfer;

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_xfer  = main_valid_q && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    assign in_ready  = !skid_valid_q;
    assign in_xfer   = in_valid && !skid_valid_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Skid full: inputs are blocked, the skid beat refills main on emit.
            if (out_ready) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (!main_valid_q || out_ready) begin
                main_data_d  = in_data;
                main_valid_d = 1'b1;
            end else begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RESET_VAL;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign in_ready  = !main_valid_q || out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign occupancy = {1'b0, main_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (in_xfer) begin
            main_data_d  = in_data;
            main_valid_d = 1'b1;
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RESET_VAL;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg, checked against a FIFO-queue
// reference model whose capacity depends on PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'h5A;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] q[$];
    bit         acc;

    pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_ready(input bit ordy);
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || ordy;
    endfunction

    // Entered at posedge+1: drive, check at the falling edge, then advance the model.
    task automatic cycle(input bit iv, input logic [7:0] d, input bit ordy, input bit fl);
        bit rdy;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #4;
        rdy = model_ready(ordy);
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) check_eq("out_data", {24'd0, out_data}, {24'd0, q[0]});
        check_eq("occupancy", {30'd0, occupancy}, q.size());
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        @(posedge clk);
        acc = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (iv && rdy) begin
                q.push_back(d);
                acc = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;
        check_eq("rst_out_valid", {31'd0, out_valid}, 0);
        check_eq("rst_occupancy", {30'd0, occupancy}, 0);
        check_eq("rst_out_data", {24'd0, out_data}, {24'd0, RV});
        check_eq("rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back stream with downstream always ready.
        cycle(1, 8'h11, 1, 0);
        cycle(1, 8'h22, 1, 0);
        cycle(1, 8'h33, 1, 0);
        cycle(1, 8'h44, 1, 0);
        check_eq("b2b_last", {24'd0, out_data}, 32'h44);
        for (int i = 0; i < 2; i++) cycle(0, 8'h00, 1, 0);

        // Backpressure: second beat goes to skid or is held off at the source.
        cycle(1, 8'h0A, 0, 0);
        cycle(1, 8'h0B, 0, 0);
        cycle(0, 8'hEE, 0, 0);
        check_eq("bp_hold_data", {24'd0, out_data}, 32'h0A);
        cycle(0, 8'hEE, 0, 0);
        if (!acc && q.size() < 2) begin
            for (int i = 0; i < 4 && !acc; i++) cycle(1, 8'h0B, 1, 0);
            check_eq("bp_b_accepted", {31'd0, acc}, 1);
        end
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0);

        // Flush while full with a simultaneous input beat.
        cycle(1, 8'h01, 0, 0);
        cycle(1, 8'h02, 0, 0);
        cycle(1, 8'h05, 0, 1);
        check_eq("flush_valid", {31'd0, out_valid}, 0);
        check_eq("flush_occ", {30'd0, occupancy}, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(1, 8'h66, 1, 0);
        cycle(0, 8'h00, 1, 0);

        // Asynchronous reset pulse between edges with one beat held.
        cycle(1, 8'h33, 0, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", {31'd0, out_valid}, 0);
        check_eq("arst_out_data", {24'd0, out_data}, {24'd0, RV});
        check_eq("arst_occupancy", {30'd0, occupancy}, 0);
        check_eq("arst_in_ready", {31'd0, in_ready}, 1);
        #1;
        rst = 1'b0;
        q.delete();
        @(posedge clk); #1;
        cycle(1, 8'h77, 1, 0);
        check_eq("arst_next", {24'd0, out_data}, 32'h77);
        cycle(0, 8'h00, 1, 0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom % 2), 8'($urandom), 1'($urandom % 2), ($urandom % 64) == 0);
        end
        check_eq("occ_bound", {31'd0, occupancy <= 2'd2}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32: data path width in bits, legal range 1..128.
REQ-002 Parameter RESET_VAL, default 0: out_data value applied on reset, WIDTH bits.
REQ-003 clk  input  1  clock; every register updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 flush  input  1  synchronous discard of all held beats.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  stage can accept a beat this cycle.
REQ-008 in_data  input  WIDTH  upstream beat payload.
REQ-009 out_valid  output  1  downstream beat present.
REQ-010 out_ready  input  1  downstream accepts the beat this cycle.
REQ-011 out_data  output  WIDTH  downstream beat payload, driven directly from the main register.
REQ-012 occupancy  output  2  number of beats held, 0..2.

Function
REQ-013 An input transfer occurs on a rising edge where in_valid && in_ready; an output transfer occurs where out_valid && out_ready.
REQ-014 Latency from input transfer to out_valid is exactly 1 cycle when the stage is empty.
REQ-015 Beats leave the stage in acceptance order; no beat is duplicated or dropped except by flush.
REQ-016 While out_valid && !out_ready, out_data and out_valid hold stable.
REQ-017 The main register loads in_data on input transfer when it is empty or emits in the same cycle; otherwise the beat takes the path given in REQ-024.
REQ-018 On an edge with out transfer and no in transfer and no held second beat, out_valid clears.
REQ-019 flush has priority over every other event: on the next edge all valid flags and occupancy go to 0, any simultaneous input beat is discarded, and the data registers keep their contents.
REQ-020 occupancy equals the count of valid main and skid entries; it is 0 or 1 when PIPE_STAGE_SKID_EN is undefined.
REQ-021 in_valid low with in_data changing never alters stage state.

Reset
REQ-022 While rst is high: out_valid=0, occupancy=0, out_data=RESET_VAL, skid entry invalid; in_ready reads 1.
REQ-023 Reset asserted mid-transfer aborts all held beats immediately, independent of clk; the first edge after deassertion behaves as from an empty stage.

Configuration
REQ-024 Macro PIPE_STAGE_SKID_EN defined: the stage holds one skid entry and in_ready is a registered signal equal to !skid_valid. A beat accepted while out_valid && !out_ready goes to the skid entry. On the next output transfer the skid beat moves to main. With skid full, out_ready and in_valid in the same cycle, no input is accepted and skid moves to main.
REQ-025 Macro PIPE_STAGE_SKID_EN undefined: there is no skid entry, and in_ready = !out_valid || out_ready combinationally. The design keeps full throughput with a combinational ready path.

Verification
REQ-026 Reset, then 4 back-to-back beats 0x11,0x22,0x33,0x44 with out_ready=1 -> out_data shows 0x11..0x44 on consecutive cycles starting 1 cycle after the first accept; occupancy stays 1.
REQ-027 Two beats 0xA,0xB are sent while out_ready=0 -> with SKID_EN, occupancy reaches 2, in_ready=0, and out_data holds 0xA; on raising out_ready, 0xA then 0xB are emitted. Without SKID_EN, 0xB is held off by in_ready=0.
REQ-028 flush asserted with occupancy=2 and in_valid=1 carrying 0x5 -> on the next cycle out_valid=0 and occupancy=0, and 0x5 never appears.
REQ-029 rst pulsed asynchronously between edges with occupancy=1 -> out_valid falls without a clock edge, out_data=RESET_VAL, and the next beat 0x77 emerges 1 cycle after acceptance.
REQ-030 Random in_valid/out_ready at 50% each over 10000 cycles, WIDTH=8, compared against a reference queue model -> order is identical, there is no loss, and occupancy is never greater than 2.
